// File: rtl/i2s_adc_receiver.sv
// -----------------------------------------------------------------------------
// i2s_adc_receiver
//
// Purpose:
//   Front end for the external stereo audio ADC. Generates the ADC master
//   clock (sclk_out), resynchronises the ADC's I2S bit clock, word select and
//   data into the clk domain, deserialises standard I2S frames (MSB first,
//   one-bclk delay after each LRCLK edge, LRCLK low = left channel) and hands
//   every completed left/right pair to the downstream audio path over a
//   strobe/acknowledge handshake.
//
// Ports:
//   clk             system clock (transceiver clock)
//   rst_n           asynchronous active-low reset, clears every flop
//   bclk_in         I2S bit clock from the ADC (asynchronous to clk)
//   lrclk_in        I2S word select from the ADC (asynchronous), low = left
//   dout_in         I2S serial data from the ADC (asynchronous)
//   sclk_out        ADC master clock, 50% duty, SCLK_HALF_PERIOD clk per half
//   left_out        left sample of the current pair, two's complement
//   right_out       right sample of the current pair, two's complement
//   sample_stb_out  high while left_out/right_out hold an unconsumed pair
//   sample_ack_in   consumer accepts the pair (sampled while strobe is high)
//   overrun_out     sticky: an unacknowledged pair was overwritten
// -----------------------------------------------------------------------------
module i2s_adc_receiver #(
    parameter int SAMPLE_WIDTH     = 24,
    parameter int SCLK_HALF_PERIOD = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    bclk_in,
    input  logic                    lrclk_in,
    input  logic                    dout_in,
    output logic                    sclk_out,
    output logic [SAMPLE_WIDTH-1:0] left_out,
    output logic [SAMPLE_WIDTH-1:0] right_out,
    output logic                    sample_stb_out,
    input  logic                    sample_ack_in,
    output logic                    overrun_out
);

    localparam int CW = (SCLK_HALF_PERIOD > 1) ? $clog2(SCLK_HALF_PERIOD) : 1;
    localparam int BW = $clog2(SAMPLE_WIDTH + 1);
    localparam logic [CW-1:0] SCLK_TC  = CW'(SCLK_HALF_PERIOD - 1);
    localparam logic [BW-1:0] BIT_FULL = BW'(SAMPLE_WIDTH);

    // sclk generator state
    logic [CW-1:0] sclk_cnt_r;

    // synchronisers (sync3 on bclk only, for rising-edge detection)
    logic bclk_sync1_r, bclk_sync2_r, bclk_sync3_r;
    logic lrclk_sync1_r, lrclk_sync2_r;
    logic dout_sync1_r, dout_sync2_r;

    // deserialiser state
    logic                    lrclk_prev_r;
    logic                    synced_r;
    logic [BW-1:0]           bit_cnt_r;
    logic [SAMPLE_WIDTH-1:0] shift_r;
    logic [SAMPLE_WIDTH-1:0] left_hold_r;
    logic [SAMPLE_WIDTH-1:0] right_hold_r;
    logic                    left_ok_r;
    logic                    pair_done_r;

    // decoded per-cycle events
    logic rise_s;
    logic boundary_s;
    logic word_valid_s;

    // Free-running master clock divider, independent of any I2S activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_cnt_r <= '0;
            sclk_out   <= 1'b0;
        end else if (sclk_cnt_r == SCLK_TC) begin
            sclk_cnt_r <= '0;
            sclk_out   <= ~sclk_out;
        end else begin
            sclk_cnt_r <= sclk_cnt_r + CW'(1);
        end
    end

    // Two-flop synchronisers for all pins, plus a third bclk stage for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bclk_sync1_r  <= 1'b0;
            bclk_sync2_r  <= 1'b0;
            bclk_sync3_r  <= 1'b0;
            lrclk_sync1_r <= 1'b0;
            lrclk_sync2_r <= 1'b0;
            dout_sync1_r  <= 1'b0;
            dout_sync2_r  <= 1'b0;
        end else begin
            bclk_sync1_r  <= bclk_in;
            bclk_sync2_r  <= bclk_sync1_r;
            bclk_sync3_r  <= bclk_sync2_r;
            lrclk_sync1_r <= lrclk_in;
            lrclk_sync2_r <= lrclk_sync1_r;
            dout_sync1_r  <= dout_in;
            dout_sync2_r  <= dout_sync1_r;
        end
    end

    // Rise pulse, LRCLK-boundary detect and validity of the word just finished.
    always_comb begin
        rise_s       = bclk_sync2_r & ~bclk_sync3_r;
        boundary_s   = rise_s & (lrclk_sync2_r != lrclk_prev_r);
        word_valid_s = synced_r & (bit_cnt_r == BIT_FULL);
    end

    // I2S deserialiser: shifts bits on each rise and evaluates words at LRCLK edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lrclk_prev_r <= 1'b0;
            synced_r     <= 1'b0;
            bit_cnt_r    <= '0;
            shift_r      <= '0;
            left_hold_r  <= '0;
            right_hold_r <= '0;
            left_ok_r    <= 1'b0;
            pair_done_r  <= 1'b0;
        end else begin
            pair_done_r <= 1'b0;
            if (rise_s) begin
                lrclk_prev_r <= lrclk_sync2_r;
                if (boundary_s) begin
                    // Delay slot: this edge's data bit belongs to no word.
                    bit_cnt_r <= '0;
                    synced_r  <= 1'b1;
                    if (!lrclk_prev_r) begin
                        if (word_valid_s) begin
                            left_hold_r <= shift_r;
                            left_ok_r   <= 1'b1;
                        end else begin
                            left_ok_r   <= 1'b0;
                        end
                    end else begin
                        // A right word only completes a pair behind a good left word.
                        if (word_valid_s && left_ok_r) begin
                            right_hold_r <= shift_r;
                            pair_done_r  <= 1'b1;
                        end else begin
                            right_hold_r <= right_hold_r;
                        end
                        left_ok_r <= 1'b0;
                    end
                end else if (bit_cnt_r < BIT_FULL) begin
                    shift_r   <= {shift_r[SAMPLE_WIDTH-2:0], dout_sync2_r};
                    bit_cnt_r <= bit_cnt_r + BW'(1);
                end else begin
                    // Bits beyond the sample width are dropped; count saturates.
                    bit_cnt_r <= bit_cnt_r;
                end
            end else begin
                lrclk_prev_r <= lrclk_prev_r;
            end
        end
    end

    // Output pair register and stb/ack handshake with sticky overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            left_out       <= '0;
            right_out      <= '0;
            sample_stb_out <= 1'b0;
            overrun_out    <= 1'b0;
        end else if (pair_done_r) begin
            left_out       <= left_hold_r;
            right_out      <= right_hold_r;
            sample_stb_out <= 1'b1;
            // An ack in the completion cycle consumes the old pair, so no overrun.
            if (sample_stb_out && !sample_ack_in) begin
                overrun_out <= 1'b1;
            end else begin
                overrun_out <= overrun_out;
            end
        end else if (sample_stb_out && sample_ack_in) begin
            sample_stb_out <= 1'b0;
        end else begin
            sample_stb_out <= sample_stb_out;
        end
    end

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// -----------------------------------------------------------------------------
// tb_i2s_adc_receiver
//
// Directed bench for i2s_adc_receiver: acts as the I2S ADC (bclk half period
// of 24 clk, lrclk/dout changed on bclk falling edges) and as the consumer
// driving sample_ack_in. Expected values are the words the bench transmits.
// -----------------------------------------------------------------------------
module tb_i2s_adc_receiver;

    localparam int W = 24;
    localparam int H = 24;   // clk cycles per bclk half period

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bclk;
    logic          lrclk;
    logic          dout;
    logic          sclk;
    logic [W-1:0]  left;
    logic [W-1:0]  right;
    logic          stb;
    logic          ack;
    logic          ovr;

    int checks = 0;
    int errors = 0;
    logic stb_pre;
    logic stb_post;

    i2s_adc_receiver #(.SAMPLE_WIDTH(24), .SCLK_HALF_PERIOD(6)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bclk_in        (bclk),
        .lrclk_in       (lrclk),
        .dout_in        (dout),
        .sclk_out       (sclk),
        .left_out       (left),
        .right_out      (right),
        .sample_stb_out (stb),
        .sample_ack_in  (ack),
        .overrun_out    (ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic half_wait();
        repeat (H) @(posedge clk);
        #1;
    endtask

    // One bclk period: lrclk/dout set at the falling edge, sampled at the rise.
    task automatic bclk_cycle(input logic lr, input logic d);
        lrclk = lr;
        dout  = d;
        half_wait();
        bclk = 1'b1;
        half_wait();
        bclk = 1'b0;
    endtask

    // Slots 1..nbits-1 of a channel: MSB first, padding ones after bit 24.
    task automatic send_body(input logic lr, input logic [W-1:0] word, input int nbits);
        for (int i = 1; i < nbits; i++) begin
            if (i - 1 < W) bclk_cycle(lr, word[W - i]);
            else           bclk_cycle(lr, 1'b1);
        end
    endtask

    task automatic send_channel(input logic lr, input logic [W-1:0] word, input int nbits);
        bclk_cycle(lr, 1'b0);
        send_body(lr, word, nbits);
    endtask

    // Delay slot of a channel with strobe observed after the 3rd and 4th clk
    // edges following the bclk rise; optionally acks in the completion cycle.
    task automatic lead_slot(input logic lr, input logic do_ack);
        lrclk = lr;
        dout  = 1'b0;
        half_wait();
        bclk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        stb_pre = stb;
        if (do_ack) ack = 1'b1;
        else        ack = 1'b0;
        @(posedge clk);
        #1;
        ack = 1'b0;
        stb_post = stb;
        repeat (H - 4) @(posedge clk);
        #1;
        bclk = 1'b0;
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
    endtask

    initial begin
        int  prev_s;
        int  found;
        int  period;
        rst_n = 1'b0;
        bclk  = 1'b0;
        lrclk = 1'b1;
        dout  = 1'b0;
        ack   = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset held low while the ADC is mid right channel.
        send_body(1'b1, 24'h000000, 6);
        chk("rst_left",  {8'h00, left},  32'h0);
        chk("rst_right", {8'h00, right}, 32'h0);
        chk("rst_stb",   {31'h0, stb},   32'h0);
        chk("rst_ovr",   {31'h0, ovr},   32'h0);
        chk("rst_sclk",  {31'h0, sclk},  32'h0);
        rst_n = 1'b1;

        // sclk: high after 6 edges, low after 12, high after 18.
        repeat (5) @(posedge clk);
        #1 chk("sclk_e5",  {31'h0, sclk}, 32'h0);
        @(posedge clk);
        #1 chk("sclk_e6",  {31'h0, sclk}, 32'h1);
        repeat (5) @(posedge clk);
        #1 chk("sclk_e11", {31'h0, sclk}, 32'h1);
        @(posedge clk);
        #1 chk("sclk_e12", {31'h0, sclk}, 32'h0);
        repeat (6) @(posedge clk);
        #1 chk("sclk_e18", {31'h0, sclk}, 32'h1);

        // Rest of the partial frame, then a full frame.
        send_body(1'b1, 24'hFFFFFF, 10);
        send_channel(1'b0, 24'h800001, 32);
        chk("first_partial_no_stb", {31'h0, stb}, 32'h0);
        send_channel(1'b1, 24'h7FFFFE, 32);
        lead_slot(1'b0, 1'b0);
        chk("nom_stb_edge3", {31'h0, stb_pre},  32'h0);
        chk("nom_stb_edge4", {31'h0, stb_post}, 32'h1);
        chk("nom_left",  {8'h00, left},  32'h00800001);
        chk("nom_right", {8'h00, right}, 32'h007FFFFE);
        chk("nom_ovr",   {31'h0, ovr},   32'h0);
        ack_pulse();
        chk("nom_ack_stb", {31'h0, stb}, 32'h0);

        // Back-pressure across two pairs.
        send_body(1'b0, 24'h555555, 32);
        send_channel(1'b1, 24'hAAAAAA, 32);
        send_channel(1'b0, 24'h000123, 32);
        chk("bp1_stb",   {31'h0, stb},   32'h1);
        chk("bp1_left",  {8'h00, left},  32'h00555555);
        chk("bp1_right", {8'h00, right}, 32'h00AAAAAA);
        chk("bp1_ovr",   {31'h0, ovr},   32'h0);
        send_channel(1'b1, 24'h000456, 32);
        // 16-bclk left channel: its word is short.
        send_channel(1'b0, 24'h123456, 16);
        chk("bp2_stb",   {31'h0, stb},   32'h1);
        chk("bp2_left",  {8'h00, left},  32'h00000123);
        chk("bp2_right", {8'h00, right}, 32'h00000456);
        chk("bp2_ovr",   {31'h0, ovr},   32'h1);
        ack_pulse();
        chk("bp_ack_stb", {31'h0, stb}, 32'h0);
        chk("bp_ovr_sticky", {31'h0, ovr}, 32'h1);

        // Short left word: the following right completes nothing.
        send_channel(1'b1, 24'h333333, 32);
        send_channel(1'b0, 24'h0000AA, 32);
        chk("short_no_stb", {31'h0, stb}, 32'h0);
        send_channel(1'b1, 24'hFFFF55, 32);
        send_channel(1'b0, 24'hABCDEF, 40);
        chk("after_short_stb",   {31'h0, stb},   32'h1);
        chk("after_short_left",  {8'h00, left},  32'h000000AA);
        chk("after_short_right", {8'h00, right}, 32'h00FFFF55);
        ack_pulse();

        // 40 bclk per channel: trailing bits ignored.
        send_channel(1'b1, 24'h13579B, 40);
        send_channel(1'b0, 24'h000000, 32);
        chk("extra_stb",   {31'h0, stb},   32'h1);
        chk("extra_left",  {8'h00, left},  32'h00ABCDEF);
        chk("extra_right", {8'h00, right}, 32'h0013579B);
        ack_pulse();

        // Second reset mid frame clears the sticky overrun.
        rst_n = 1'b0;
        send_body(1'b1, 24'h000000, 8);
        rst_n = 1'b1;
        #1 chk("rst2_ovr", {31'h0, ovr}, 32'h0);
        chk("rst2_left", {8'h00, left}, 32'h0);
        send_body(1'b1, 24'h000000, 20);
        send_channel(1'b0, 24'h00F00F, 32);
        send_channel(1'b1, 24'h0FF0FF, 32);
        send_channel(1'b0, 24'h135790, 32);
        chk("sim1_stb",   {31'h0, stb},   32'h1);
        chk("sim1_left",  {8'h00, left},  32'h0000F00F);
        chk("sim1_right", {8'h00, right}, 32'h000FF0FF);
        send_channel(1'b1, 24'h97531F, 32);
        // Ack lands exactly in the completion cycle.
        lead_slot(1'b0, 1'b1);
        chk("sim_stb_pre",  {31'h0, stb_pre},  32'h1);
        chk("sim_stb_post", {31'h0, stb_post}, 32'h1);
        chk("sim_left",  {8'h00, left},  32'h00135790);
        chk("sim_right", {8'h00, right}, 32'h0097531F);
        chk("sim_ovr",   {31'h0, ovr},   32'h0);
        ack_pulse();
        chk("sim_ack_stb", {31'h0, stb}, 32'h0);

        // bclk stopped: no strobes, sclk keeps its 12-clk period.
        repeat (300) @(posedge clk);
        #1 chk("idle_stb", {31'h0, stb}, 32'h0);
        found  = 0;
        prev_s = int'(sclk);
        for (int i = 0; i < 30 && found == 0; i++) begin
            @(posedge clk);
            #1;
            if (prev_s == 0 && sclk == 1'b1) found = 1;
            prev_s = int'(sclk);
        end
        chk("idle_sclk_found", found, 32'h1);
        period = 0;
        found  = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            @(posedge clk);
            #1;
            period++;
            if (prev_s == 0 && sclk == 1'b1) found = 1;
            prev_s = int'(sclk);
        end
        chk("idle_sclk_period", period, 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
